// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and defaults for the scratch-memory request controller.
package mem_req_ctrl_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 8;
   localparam int STAT_W_DEF = 16;

   // Controller phases: wait for request, strobe memory, capture read data, offer response.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      LATCH = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Registered copy of an accepted request (widths follow the package defaults).
   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } req_t;

endpackage

// File: rtl/mem_req_stats.sv
// Pair of saturating completion counters (reads and writes).
// A synchronous clear wins over an increment in the same cycle.
module mem_req_stats #(
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc_rd,
   input  logic              inc_wr,
   output logic [STAT_W-1:0] rd_cnt,
   output logic [STAT_W-1:0] wr_cnt
);

   // Read counter: clear first, otherwise count up and stick at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt <= '0;
      end else if (clr) begin
         rd_cnt <= '0;
      end else if (inc_rd && (rd_cnt != '1)) begin
         rd_cnt <= rd_cnt + 1'b1;
      end
   end

   // Write counter: same policy as the read counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt <= '0;
      end else if (clr) begin
         wr_cnt <= '0;
      end else if (inc_wr && (wr_cnt != '1)) begin
         wr_cnt <= wr_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request-side controller for the 32x8 scratch memory.
// Optional build macro: MEMCTRL_STATS_EN adds completed-response counters
// (stat_rd_cnt / stat_wr_cnt) with a synchronous stat_clr input.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The controller raises req_ready only in IDLE and holds
// rsp_valid and rsp_rdata stable in RESP until rsp_ready is seen; neither
// ready depends on the matching valid in the same cycle.
module mem_req_ctrl
   import mem_req_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
`ifdef MEMCTRL_STATS_EN
   ,
   parameter int STAT_W = STAT_W_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEMCTRL_STATS_EN
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_rd_cnt,
   output logic [STAT_W-1:0] stat_wr_cnt,
`endif
   output logic [1:0]        dbg_state
);

   state_t            state;
   state_t            state_nxt;
   req_t              req_q;
   logic [DATA_W-1:0] rdata_q;
   logic              req_fire;

   assign req_fire = req_valid && req_ready;

   // State register; reset returns to IDLE so the strobes drop with rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and strobes decoded from state alone (glitch-free outputs).
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            mem_write = req_q.we;
            mem_read  = !req_q.we;
            state_nxt = req_q.we ? RESP : LATCH;
         end
         LATCH: begin
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Request capture on acceptance; read data captured in LATCH, cleared for write acks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         rdata_q <= '0;
      end else begin
         if (req_fire) begin
            req_q <= '{we: req_we, addr: req_addr, wdata: req_wdata};
         end
         if ((state == ISSUE) && req_q.we) begin
            rdata_q <= '0;
         end else if (state == LATCH) begin
            rdata_q <= mem_rdata;
         end
      end
   end

   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;
   assign rsp_rdata = rdata_q;
   assign dbg_state = state;

`ifdef MEMCTRL_STATS_EN
   logic rsp_fire;

   assign rsp_fire = rsp_valid && rsp_ready;

   mem_req_stats #(
      .STAT_W (STAT_W)
   ) u_stats (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (stat_clr),
      .inc_rd (rsp_fire && !req_q.we),
      .inc_wr (rsp_fire && req_q.we),
      .rd_cnt (stat_rd_cnt),
      .wr_cnt (stat_wr_cnt)
   );
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl paired with a 32x8 registered-read memory model.
// Expected read data comes from a plain array of last-written values.
`timescale 1ns/1ps
module tb_mem_req_ctrl;
   import mem_req_ctrl_pkg::*;

   localparam int AW = 5;
   localparam int DW = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic [1:0]    dbg_state;
`ifdef MEMCTRL_STATS_EN
   logic          stat_clr = 1'b0;
   logic [15:0]   stat_rd_cnt;
   logic [15:0]   stat_wr_cnt;
   logic [1:0]    s2_rd_cnt;
   logic [1:0]    s2_wr_cnt;
   logic          s2_req_ready, s2_rsp_valid, s2_mem_read, s2_mem_write;
   logic [DW-1:0] s2_rsp_rdata, s2_mem_wdata;
   logic [AW-1:0] s2_mem_addr;
   logic [1:0]    s2_dbg_state;
`endif

   mem_req_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
`ifdef MEMCTRL_STATS_EN
      .stat_clr   (stat_clr),
      .stat_rd_cnt(stat_rd_cnt),
      .stat_wr_cnt(stat_wr_cnt),
`endif
      .dbg_state  (dbg_state)
   );

`ifdef MEMCTRL_STATS_EN
   // Second copy with 2-bit counters, fed identical inputs, to observe saturation.
   mem_req_ctrl #(.STAT_W(2)) dut_s2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (s2_req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (s2_rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (s2_rsp_rdata),
      .mem_read   (s2_mem_read),
      .mem_write  (s2_mem_write),
      .mem_addr   (s2_mem_addr),
      .mem_wdata  (s2_mem_wdata),
      .mem_rdata  (mem_rdata),
      .stat_clr   (stat_clr),
      .stat_rd_cnt(s2_rd_cnt),
      .stat_wr_cnt(s2_wr_cnt),
      .dbg_state  (s2_dbg_state)
   );
`endif

   // ---------------- memory model ----------------
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr];
   end

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] ref_mem [32];
   bit            ref_known [32];
   logic [DW-1:0] exp_q [$];
   int            checks = 0;
   int            errors = 0;

   // ---------------- driver ----------------
   // One request; observes latency (cycles after the accept cycle to first rsp_valid),
   // strobe counts, returned data and stability while rsp_ready is held low for bp cycles.
   task automatic run_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int bp, output int lat, output int n_rd, output int n_wr,
                         output logic [DW-1:0] rdata, output bit held_ok);
      bit accepted;
      lat = -1; n_rd = 0; n_wr = 0; rdata = '0; held_ok = 1'b1; accepted = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
      if (!accepted) return;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (mem_read)  n_rd++;
         if (mem_write) n_wr++;
         if (rsp_valid) begin
            lat = c;
            break;
         end
      end
      if (lat < 0) return;
      rdata = rsp_rdata;
      if (bp > 0) req_valid = 1'b1;
      for (int h = 0; h < bp; h++) begin
         @(negedge clk);
         if (!rsp_valid || rsp_rdata !== rdata || req_ready || mem_read || mem_write)
            held_ok = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
   endtask

   // Reference: result a request should produce, applying writes to the model.
   task automatic model_op(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           output logic [DW-1:0] exp, output bit known);
      if (we) begin
         ref_mem[addr] = wdata;
         ref_known[addr] = 1'b1;
         exp = '0;
         known = 1'b1;
      end else begin
         exp = ref_mem[addr];
         known = ref_known[addr];
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      bit accepted;
      accepted = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: rsp_valid=%b mem_read=%b mem_write=%b, need 0 0 0",
                  rsp_valid, mem_read, mem_write);
      end
      checks++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         errors++;
         $display("FAIL reset_regs: mem_addr=%0d mem_wdata=%0h, need 0 0", mem_addr, mem_wdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: req_ready=%b, need 1", req_ready);
      end
      // Write into ISSUE, then reset while the write strobe is up.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 8'h77;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (req_ready) begin
            accepted = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (!accepted || mem_write !== 1'b1) begin
         errors++;
         $display("FAIL reset_issue_write: accepted=%b mem_write=%b, need 1 1", accepted, mem_write);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobe_drop: mem_write=%b mem_read=%b, need 0 0", mem_write, mem_read);
      end
      ref_known[9] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: req_ready=%b rsp_valid=%b, need 1 0", req_ready, rsp_valid);
      end
   endtask

   task automatic test_write();
      int lat, n_rd, n_wr; logic [DW-1:0] rd, exp; bit ok, known;
      model_op(1'b1, 5'd5, 8'hA5, exp, known);
      run_op(1'b1, 5'd5, 8'hA5, 0, lat, n_rd, n_wr, rd, ok);
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL write_latency: got %0d cycles, need 2", lat);
      end
      checks++;
      if (n_wr !== 1 || n_rd !== 0) begin
         errors++; $display("FAIL write_strobes: wr=%0d rd=%0d, need 1 0", n_wr, n_rd);
      end
      checks++;
      if (rd !== exp) begin
         errors++; $display("FAIL write_ack_data: got %0h, need %0h", rd, exp);
      end
   endtask

   task automatic test_read();
      int lat, n_rd, n_wr; logic [DW-1:0] rd, exp; bit ok, known;
      model_op(1'b0, 5'd5, 8'h00, exp, known);
      run_op(1'b0, 5'd5, 8'h00, 0, lat, n_rd, n_wr, rd, ok);
      checks++;
      if (lat !== 3) begin
         errors++; $display("FAIL read_latency: got %0d cycles, need 3", lat);
      end
      checks++;
      if (n_rd !== 1 || n_wr !== 0) begin
         errors++; $display("FAIL read_strobes: rd=%0d wr=%0d, need 1 0", n_rd, n_wr);
      end
      checks++;
      if (rd !== 8'hA5 || exp !== 8'hA5) begin
         errors++; $display("FAIL read_data: got %0h, need a5", rd);
      end
   endtask

   task automatic test_backpressure();
      int lat, n_rd, n_wr; logic [DW-1:0] rd, exp; bit ok, known;
      model_op(1'b1, 5'd31, 8'h3C, exp, known);
      run_op(1'b1, 5'd31, 8'h3C, 0, lat, n_rd, n_wr, rd, ok);
      model_op(1'b0, 5'd31, 8'h00, exp, known);
      run_op(1'b0, 5'd31, 8'h00, 5, lat, n_rd, n_wr, rd, ok);
      checks++;
      if (rd !== exp) begin
         errors++; $display("FAIL bp_data: got %0h, need %0h", rd, exp);
      end
      checks++;
      if (ok !== 1'b1 || lat !== 3) begin
         errors++; $display("FAIL bp_hold: stable=%b latency=%0d, need 1 3", ok, lat);
      end
   endtask

   task automatic test_back_to_back();
      int n_acc, n_rsp, n_rd, n_wr, both, last_acc, cyc, gap_err;
      bit cur_we, prev_we, done;
      logic [AW-1:0] last_waddr;
      logic [DW-1:0] exp, got; bit known;
      bit known_q [$];
      n_acc = 0; n_rsp = 0; n_rd = 0; n_wr = 0; both = 0; last_acc = -1; gap_err = 0;
      prev_we = 1'b0; cur_we = 1'b1; last_waddr = '0; done = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1; req_valid = 1'b1;
      req_we = cur_we; req_addr = AW'($urandom); req_wdata = DW'($urandom);
      for (cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         if (mem_read && mem_write) both++;
         if (mem_read)  n_rd++;
         if (mem_write) n_wr++;
         if (rsp_valid && rsp_ready) begin
            n_rsp++;
            got = rsp_rdata;
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               known = known_q.pop_front();
               if (known) begin
                  checks++;
                  if (got !== exp) begin
                     errors++; $display("FAIL b2b_data: rsp %0d got %0h, need %0h", n_rsp, got, exp);
                  end
               end
            end
         end
         if (req_valid && req_ready) begin
            if (last_acc >= 0 && (cyc - last_acc) != (prev_we ? 3 : 4)) gap_err++;
            last_acc = cyc;
            prev_we = req_we;
            model_op(req_we, req_addr, req_wdata, exp, known);
            exp_q.push_back(exp);
            known_q.push_back(known);
            if (req_we) last_waddr = req_addr;
            n_acc++;
            @(posedge clk); #1;
            if (n_acc == 20) begin
               req_valid = 1'b0;
            end else begin
               cur_we = !cur_we;
               req_we = cur_we;
               req_wdata = DW'($urandom);
               req_addr = (!cur_we && $urandom_range(0, 1) == 1) ? last_waddr : AW'($urandom);
            end
         end
         if (n_acc == 20 && n_rsp == 20) done = 1'b1;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks++;
      if (n_acc !== 20 || n_rsp !== 20) begin
         errors++; $display("FAIL b2b_count: accepts=%0d responses=%0d, need 20 20", n_acc, n_rsp);
      end
      checks++;
      if (both !== 0) begin
         errors++; $display("FAIL b2b_exclusive: read&write together %0d cycles, need 0", both);
      end
      checks++;
      if (n_rd !== 10 || n_wr !== 10) begin
         errors++; $display("FAIL b2b_one_op: reads=%0d writes=%0d, need 10 10", n_rd, n_wr);
      end
      checks++;
      if (gap_err !== 0) begin
         errors++; $display("FAIL b2b_throughput: %0d wrong accept gaps, need 0", gap_err);
      end
   endtask

   task automatic test_random();
      int lat, n_rd, n_wr, bp; logic [DW-1:0] rd, exp, wd; logic [AW-1:0] a;
      bit ok, known, we;
      for (int i = 0; i < 30; i++) begin
         we = 1'($urandom);
         a = AW'($urandom_range(0, 7));
         wd = DW'($urandom);
         bp = $urandom_range(0, 3);
         model_op(we, a, wd, exp, known);
         run_op(we, a, wd, bp, lat, n_rd, n_wr, rd, ok);
         checks++;
         if (lat !== (we ? 2 : 3) || n_rd !== (we ? 0 : 1) || n_wr !== (we ? 1 : 0) || !ok) begin
            errors++;
            $display("FAIL rand_timing: op %0d we=%b lat=%0d rd=%0d wr=%0d stable=%b, need lat %0d",
                     i, we, lat, n_rd, n_wr, ok, we ? 2 : 3);
         end
         if (known) begin
            checks++;
            if (rd !== exp) begin
               errors++; $display("FAIL rand_data: op %0d addr %0d got %0h, need %0h", i, a, rd, exp);
            end
         end
      end
   endtask

`ifdef MEMCTRL_STATS_EN
   task automatic test_stats();
      int lat, n_rd, n_wr; logic [DW-1:0] rd, exp; bit ok, known;
      @(posedge clk); #1 stat_clr = 1'b1;
      @(posedge clk); #1 stat_clr = 1'b0;
      checks++;
      if (stat_rd_cnt !== 16'd0 || stat_wr_cnt !== 16'd0) begin
         errors++; $display("FAIL stats_clr0: rd=%0d wr=%0d, need 0 0", stat_rd_cnt, stat_wr_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         bit we;
         we = (i == 1 || i == 3);
         model_op(we, 5'd2, DW'(i), exp, known);
         run_op(we, 5'd2, DW'(i), 0, lat, n_rd, n_wr, rd, ok);
      end
      checks++;
      if (stat_rd_cnt !== 16'd3 || stat_wr_cnt !== 16'd2) begin
         errors++; $display("FAIL stats_count: rd=%0d wr=%0d, need 3 2", stat_rd_cnt, stat_wr_cnt);
      end
      for (int i = 0; i < 2; i++) begin
         model_op(1'b0, 5'd2, 8'h00, exp, known);
         run_op(1'b0, 5'd2, 8'h00, 0, lat, n_rd, n_wr, rd, ok);
      end
      checks++;
      if (s2_rd_cnt !== 2'd3 || stat_rd_cnt !== 16'd5) begin
         errors++; $display("FAIL stats_saturate: narrow rd=%0d wide rd=%0d, need 3 5", s2_rd_cnt, stat_rd_cnt);
      end
      @(posedge clk); #1 stat_clr = 1'b1;
      @(posedge clk); #1 stat_clr = 1'b0;
      checks++;
      if (stat_rd_cnt !== 16'd0 || stat_wr_cnt !== 16'd0 || s2_rd_cnt !== 2'd0 || s2_wr_cnt !== 2'd0) begin
         errors++; $display("FAIL stats_clr1: rd=%0d wr=%0d narrow %0d %0d, need all 0",
                            stat_rd_cnt, stat_wr_cnt, s2_rd_cnt, s2_wr_cnt);
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      for (int i = 0; i < 32; i++) begin
         ref_mem[i] = '0;
         ref_known[i] = 1'b0;
      end
      test_reset();
      test_write();
      test_read();
      test_backpressure();
      test_back_to_back();
      test_random();
`ifdef MEMCTRL_STATS_EN
      test_stats();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
